alwr_skid: RTL



---
 rtl/alwr_skid_if.sv | 19 +
 rtl/alwr_skid.sv | 103 ++++++++++
 2 files changed

// File: rtl/alwr_skid_if.sv
// Write-channel bundle (word address, data, source id) with valid/ready handshake.
interface alwr_skid_if #(
   parameter int unsigned DATA_BITS   = 2,
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned SLAVE_COUNT = 1
);
   localparam int unsigned DATA_WIDTH = 8 << DATA_BITS;
   localparam int unsigned WA_WIDTH   = ADDR_WIDTH - DATA_BITS;
   localparam int unsigned ID_WIDTH   = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;

   logic [WA_WIDTH-1:0]   waddr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [ID_WIDTH-1:0]   wid;
   logic                  wvalid;
   logic                  wready;

   modport master (output waddr, output wdata, output wid, output wvalid, input  wready);
   modport slave  (input  waddr, input  wdata, input  wid, input  wvalid, output wready);
endinterface

// File: rtl/alwr_skid.sv
// Two-entry registered skid slice after the AL write mux; breaks the ready path
// and returns a one-cycle per-source completion strobe for each consumed beat.
module alwr_skid #(
   parameter int unsigned DATA_BITS   = 2,
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned SLAVE_COUNT = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   alwr_skid_if.slave             s_al,
   alwr_skid_if.master            m_al,
   output logic [SLAVE_COUNT-1:0] wdone
);
   localparam int unsigned DATA_WIDTH = 8 << DATA_BITS;
   localparam int unsigned WA_WIDTH   = ADDR_WIDTH - DATA_BITS;
   localparam int unsigned ID_WIDTH   = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;

   typedef struct packed {
      logic [WA_WIDTH-1:0]   waddr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [ID_WIDTH-1:0]   wid;
   } beat_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

   state_e                 state_q, state_d;
   beat_t                  main_q, main_d;
   beat_t                  skid_q, skid_d;
   beat_t                  in_beat;
   logic                   m_vld_q;
   logic                   s_rdy_q;
   logic [SLAVE_COUNT-1:0] wdone_q, wdone_d;
   logic                   s_fire, m_fire;

   assign in_beat = '{waddr: s_al.waddr, wdata: s_al.wdata, wid: s_al.wid};
   assign s_fire  = s_al.wvalid & s_rdy_q;
   assign m_fire  = m_vld_q & m_al.wready;

   // Control state; valid/ready are re-registered from the next state so no
   // combinational path exists from m_al.wready to s_al.wready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         m_vld_q <= 1'b0;
         s_rdy_q <= 1'b0;
         wdone_q <= '0;
      end else begin
         state_q <= state_d;
         m_vld_q <= (state_d != EMPTY);
         s_rdy_q <= (state_d != FULL);
         wdone_q <= wdone_d;
      end
   end

   // Payload carries no reset; it is qualified by m_vld_q.
   always_ff @(posedge clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      wdone_d = '0;
      unique case (state_q)
         EMPTY: begin
            if (s_fire) begin
               main_d  = in_beat;
               state_d = ONE;
            end
         end
         ONE: begin
            if (s_fire && !m_fire) begin
               skid_d  = in_beat;
               state_d = FULL;
            end else if (s_fire && m_fire) begin
               main_d  = in_beat;
            end else if (m_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (m_fire) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Out-of-range ids match no bit and so produce no strobe.
      for (int unsigned i = 0; i < SLAVE_COUNT; i++) begin
         wdone_d[i] = m_fire && (main_q.wid == ID_WIDTH'(i));
      end
   end

   assign s_al.wready = s_rdy_q;
   assign m_al.wvalid = m_vld_q;
   assign m_al.waddr  = main_q.waddr;
   assign m_al.wdata  = main_q.wdata;
   assign m_al.wid    = main_q.wid;
   assign wdone       = wdone_q;
endmodule
